// File: rtl/stepdir_dispatch.sv
// Command-side controller for a bank of stepdir channels: assembles move
// records from a 32-bit command stream and writes them into per-channel FIFOs.
module stepdir_dispatch #(
  parameter int NUM_CHANNELS = 6,
  parameter int DATA_WIDTH   = 100,
  parameter int MOVE_COUNT   = 512,
  parameter int WORDS        = (DATA_WIDTH + 31) / 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [NUM_CHANNELS-1:0] cmd_arg,
  input  logic [31:0]             cmd_data,
  input  logic [NUM_CHANNELS-1:0] ch_consumed,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [NUM_CHANNELS-1:0] wr_en,
  output logic [NUM_CHANNELS-1:0] do_reset_clock,
  output logic [31:0]             reset_clock,
  output logic [NUM_CHANNELS-1:0] ch_reset,
  output logic                    error
);

  localparam logic [1:0] OP_MOVE_WORD   = 2'd0;
  localparam logic [1:0] OP_MOVE_COMMIT = 2'd1;
  localparam logic [1:0] OP_RESET_CLOCK = 2'd2;
  localparam logic [1:0] OP_QUEUE_RESET = 2'd3;

  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int OCC_W  = $clog2(MOVE_COUNT) + 1;
  localparam int OCCX_W = OCC_W + 1;
  localparam int WCNT_W = $clog2(WORDS + 1);
  localparam int ASM_W  = WORDS * 32;

  logic [ASM_W-1:0]        asm_reg, asm_next;
  logic [WCNT_W-1:0]       wcnt_reg, wcnt_next;
  logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;
  logic [NUM_CHANNELS-1:0] wr_en_reg, wr_en_next;
  logic [NUM_CHANNELS-1:0] drc_reg, drc_next;
  logic [31:0]             reset_clock_reg, reset_clock_next;
  logic [NUM_CHANNELS-1:0] ch_reset_reg, ch_reset_next;
  logic                    error_reg, error_next;

  logic [OCC_W-1:0]        occ_reg [NUM_CHANNELS];
  logic [1:0]              blk_reg [NUM_CHANNELS];

  logic [CH_W-1:0]         ch_idx;
  logic [NUM_CHANNELS-1:0] ch_onehot;
  logic [NUM_CHANNELS-1:0] full_vec;
  logic [NUM_CHANNELS-1:0] blocked_vec;
  logic [NUM_CHANNELS-1:0] underflow_vec;
  logic                    ch_ok;
  logic                    words_ok;
  logic                    commit_stall;
  logic                    cmd_accept;
  logic                    qr_accept;

  assign ch_idx   = cmd_arg[CH_W-1:0];
  assign ch_ok    = (32'(ch_idx) < 32'(NUM_CHANNELS));
  assign words_ok = (wcnt_reg == WCNT_W'(WORDS));

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    assign ch_onehot[gi] = (ch_idx == CH_W'(gi));

    // A write still in flight on wr_en counts as already occupying a slot.
    assign full_vec[gi] = (OCCX_W'(occ_reg[gi]) + OCCX_W'(wr_en_reg[gi]))
                          >= OCCX_W'(MOVE_COUNT);
    assign blocked_vec[gi]   = (blk_reg[gi] != 2'd0);
    assign underflow_vec[gi] = ch_consumed[gi] && (occ_reg[gi] == '0)
                               && !ch_reset_reg[gi];

    always_ff @(posedge clk) begin
      if (reset) begin
        occ_reg[gi] <= '0;
      end else if (ch_reset_reg[gi]) begin
        occ_reg[gi] <= '0;
      end else if (wr_en_reg[gi] && !ch_consumed[gi]) begin
        occ_reg[gi] <= occ_reg[gi] + OCC_W'(1);
      end else if (!wr_en_reg[gi] && ch_consumed[gi] && (occ_reg[gi] != '0)) begin
        occ_reg[gi] <= occ_reg[gi] - OCC_W'(1);
      end
    end

    // Covers the strobe cycle and the one after, while queue_empty settles.
    always_ff @(posedge clk) begin
      if (reset) begin
        blk_reg[gi] <= 2'd0;
      end else if (qr_accept && cmd_arg[gi]) begin
        blk_reg[gi] <= 2'd2;
      end else if (blk_reg[gi] != 2'd0) begin
        blk_reg[gi] <= blk_reg[gi] - 2'd1;
      end
    end
  end

  assign commit_stall = cmd_valid && (cmd_op == OP_MOVE_COMMIT) && words_ok && ch_ok
                        && (|(ch_onehot & (full_vec | blocked_vec)));
  assign cmd_ready  = !reset && !commit_stall;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign qr_accept  = cmd_accept && (cmd_op == OP_QUEUE_RESET);

  always_comb begin
    asm_next         = asm_reg;
    wcnt_next        = wcnt_reg;
    wr_data_next     = wr_data_reg;
    wr_en_next       = '0;
    drc_next         = '0;
    reset_clock_next = reset_clock_reg;
    ch_reset_next    = '0;
    error_next       = error_reg | (|underflow_vec);
    if (cmd_accept) begin
      unique case (cmd_op)
        OP_MOVE_WORD: begin
          asm_next = (asm_reg << 32) | ASM_W'(cmd_data);
          if (!words_ok) begin
            wcnt_next = wcnt_reg + WCNT_W'(1);
          end
        end
        OP_MOVE_COMMIT: begin
          if (!words_ok) begin
            error_next = 1'b1;
            wcnt_next  = '0;
          end else if (!ch_ok) begin
            error_next = 1'b1;
          end else begin
            wr_data_next = asm_reg[DATA_WIDTH-1:0];
            wr_en_next   = ch_onehot;
            wcnt_next    = '0;
          end
        end
        OP_RESET_CLOCK: begin
          reset_clock_next = cmd_data;
          drc_next         = cmd_arg;
        end
        OP_QUEUE_RESET: begin
          ch_reset_next = cmd_arg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_reg         <= '0;
      wcnt_reg        <= '0;
      wr_data_reg     <= '0;
      wr_en_reg       <= '0;
      drc_reg         <= '0;
      reset_clock_reg <= '0;
      ch_reset_reg    <= '0;
      error_reg       <= 1'b0;
    end else begin
      asm_reg         <= asm_next;
      wcnt_reg        <= wcnt_next;
      wr_data_reg     <= wr_data_next;
      wr_en_reg       <= wr_en_next;
      drc_reg         <= drc_next;
      reset_clock_reg <= reset_clock_next;
      ch_reset_reg    <= ch_reset_next;
      error_reg       <= error_next;
    end
  end

  assign wr_data        = wr_data_reg;
  assign wr_en          = wr_en_reg;
  assign do_reset_clock = drc_reg;
  assign reset_clock    = reset_clock_reg;
  assign ch_reset       = ch_reset_reg;
  assign error          = error_reg;

endmodule

// File: tb/tb_stepdir_dispatch.sv
// Directed bench for stepdir_dispatch: a vector table for single-command
// behaviour plus hand-written sequences for stalls, blocking and resets.
`timescale 1ns/1ps
module tb_stepdir_dispatch;

  localparam logic [1:0] OP_W  = 2'd0;
  localparam logic [1:0] OP_C  = 2'd1;
  localparam logic [1:0] OP_RC = 2'd2;
  localparam logic [1:0] OP_QR = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_arg = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic [5:0]  ch_consumed = 6'd0;
  logic [99:0] wr_data;
  logic [5:0]  wr_en;
  logic [5:0]  do_reset_clock;
  logic [31:0] reset_clock;
  logic [5:0]  ch_reset;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;

  stepdir_dispatch dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_data(cmd_data),
    .ch_consumed(ch_consumed), .wr_data(wr_data), .wr_en(wr_en),
    .do_reset_clock(do_reset_clock), .reset_clock(reset_clock),
    .ch_reset(ch_reset), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  arg;
    logic [31:0] data;
    logic [5:0]  wr_en;
    logic [99:0] wr_data;
    logic [5:0]  drc;
    logic [31:0] rclk;
    logic [5:0]  chr;
    logic        err;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mkv(input logic [1:0] op, input logic [5:0] arg,
                               input logic [31:0] data, input logic [5:0] we,
                               input logic [99:0] wd, input logic [5:0] drc,
                               input logic [31:0] rclk, input logic [5:0] chr,
                               input logic err);
    vec_t v;
    v.op = op; v.arg = arg; v.data = data; v.wr_en = we; v.wr_data = wd;
    v.drc = drc; v.rclk = rclk; v.chr = chr; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the strobe cycle.
  task automatic issue(input logic [1:0] op, input logic [5:0] arg,
                       input logic [31:0] data, output int stalls);
    cmd_op = op; cmd_arg = arg; cmd_data = data; cmd_valid = 1'b1;
    stalls = 0;
    #1;
    while (!cmd_ready && stalls < 1000) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (!cmd_ready) begin
      n_checks++; n_errors++;
      $display("FAIL handshake_timeout: cmd_ready stayed 0, required 1");
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_words(input int n, input logic [31:0] base);
    int s;
    for (int i = 0; i < n; i++) issue(OP_W, 6'd0, base + 32'(i), s);
  endtask

  task automatic commit_move(input logic [5:0] ch, input logic [31:0] base);
    int s;
    load_words(4, base);
    issue(OP_C, ch, 32'd0, s);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; ch_consumed = 6'd0; reset = 1'b1;
    #1 chk("ready_low_in_reset", cmd_ready, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("rst_wr_en", wr_en, 6'd0);
    chk("rst_wr_data", wr_data, 100'd0);
    chk("rst_do_reset_clock", do_reset_clock, 6'd0);
    chk("rst_reset_clock", reset_clock, 32'd0);
    chk("rst_ch_reset", ch_reset, 6'd0);
    chk("rst_error", error, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    $display("reset applied");
  endtask

  localparam logic [99:0] D1 = 100'hA_11111111_22222222_33333333;
  localparam logic [99:0] D2 = 100'h1_00000002_00000003_00000004;

  initial begin
    int s;

    vecs[0]  = mkv(OP_W,  6'd0,       32'h0000000A, 6'd0,       100'd0, 6'd0,       32'd0,        6'd0,       1'b0);
    vecs[1]  = mkv(OP_W,  6'd0,       32'h11111111, 6'd0,       100'd0, 6'd0,       32'd0,        6'd0,       1'b0);
    vecs[2]  = mkv(OP_W,  6'd0,       32'h22222222, 6'd0,       100'd0, 6'd0,       32'd0,        6'd0,       1'b0);
    vecs[3]  = mkv(OP_W,  6'd0,       32'h33333333, 6'd0,       100'd0, 6'd0,       32'd0,        6'd0,       1'b0);
    vecs[4]  = mkv(OP_C,  6'd2,       32'd0,        6'b000100,  D1,     6'd0,       32'd0,        6'd0,       1'b0);
    vecs[5]  = mkv(OP_RC, 6'b101000,  32'hDEADBEEF, 6'd0,       D1,     6'b101000,  32'hDEADBEEF, 6'd0,       1'b0);
    vecs[6]  = mkv(OP_QR, 6'b000100,  32'd0,        6'd0,       D1,     6'd0,       32'hDEADBEEF, 6'b000100,  1'b0);
    vecs[7]  = mkv(OP_W,  6'd0,       32'd1,        6'd0,       D1,     6'd0,       32'hDEADBEEF, 6'd0,       1'b0);
    vecs[8]  = mkv(OP_W,  6'd0,       32'd2,        6'd0,       D1,     6'd0,       32'hDEADBEEF, 6'd0,       1'b0);
    vecs[9]  = mkv(OP_W,  6'd0,       32'd3,        6'd0,       D1,     6'd0,       32'hDEADBEEF, 6'd0,       1'b0);
    vecs[10] = mkv(OP_W,  6'd0,       32'd4,        6'd0,       D1,     6'd0,       32'hDEADBEEF, 6'd0,       1'b0);
    vecs[11] = mkv(OP_C,  6'd0,       32'd0,        6'b000001,  D2,     6'd0,       32'hDEADBEEF, 6'd0,       1'b0);
    vecs[12] = mkv(OP_RC, 6'b000001,  32'h12345678, 6'd0,       D2,     6'b000001,  32'h12345678, 6'd0,       1'b0);
    vecs[13] = mkv(OP_W,  6'd0,       32'd7,        6'd0,       D2,     6'd0,       32'h12345678, 6'd0,       1'b0);
    vecs[14] = mkv(OP_W,  6'd0,       32'd8,        6'd0,       D2,     6'd0,       32'h12345678, 6'd0,       1'b0);
    vecs[15] = mkv(OP_W,  6'd0,       32'd9,        6'd0,       D2,     6'd0,       32'h12345678, 6'd0,       1'b0);
    vecs[16] = mkv(OP_C,  6'd0,       32'd0,        6'd0,       D2,     6'd0,       32'h12345678, 6'd0,       1'b1);
    vecs[17] = mkv(OP_W,  6'd0,       32'd0,        6'd0,       D2,     6'd0,       32'h12345678, 6'd0,       1'b1);

    @(negedge clk);
    do_reset();

    // Table-driven single commands
    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].op, vecs[i].arg, vecs[i].data, s);
      chk($sformatf("v%0d_wr_en", i), wr_en, vecs[i].wr_en);
      chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].wr_data);
      chk($sformatf("v%0d_do_reset_clock", i), do_reset_clock, vecs[i].drc);
      chk($sformatf("v%0d_reset_clock", i), reset_clock, vecs[i].rclk);
      chk($sformatf("v%0d_ch_reset", i), ch_reset, vecs[i].chr);
      chk($sformatf("v%0d_error", i), error, vecs[i].err);
      $display("vec %0d op=%0d arg=%b data=%h -> wr_en=%b drc=%b ch_reset=%b error=%b",
               i, vecs[i].op, vecs[i].arg, vecs[i].data, wr_en, do_reset_clock, ch_reset, error);
    end
    @(negedge clk);
    chk("error_sticky", error, 1'b1);
    chk("occ2_after_queue_reset", dut.occ_reg[2], 10'd0);

    // Full-FIFO stall on channel 1
    do_reset();
    for (int i = 0; i < 512; i++) commit_move(6'd1, 32'(i));
    load_words(4, 32'h55);
    chk("occ1_full", dut.occ_reg[1], 10'd512);
    cmd_op = OP_C; cmd_arg = 6'd1; cmd_data = 32'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("full_stall_ready_%0d", i), cmd_ready, 1'b0);
      chk($sformatf("full_stall_wr_en_%0d", i), wr_en, 6'd0);
      @(negedge clk);
    end
    ch_consumed = 6'b000010;
    @(negedge clk);
    ch_consumed = 6'd0;
    #1 chk("full_release_ready", cmd_ready, 1'b1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("full_release_wr_en", wr_en, 6'b000010);
    @(negedge clk);
    chk("full_release_wr_en_drop", wr_en, 6'd0);
    chk("occ1_still_full", dut.occ_reg[1], 10'd512);
    chk("full_no_error", error, 1'b0);
    $display("full-FIFO stall sequence done, occ1=%0d", dut.occ_reg[1]);

    // Simultaneous write and consume, then underflow
    do_reset();
    chk("occ1_cleared_by_reset", dut.occ_reg[1], 10'd0);
    for (int i = 0; i < 5; i++) commit_move(6'd0, 32'(i));
    @(negedge clk);
    chk("occ0_five", dut.occ_reg[0], 10'd5);
    commit_move(6'd0, 32'h99);
    chk("simul_wr_en", wr_en, 6'b000001);
    ch_consumed = 6'b000001;
    @(negedge clk);
    ch_consumed = 6'd0;
    chk("simul_occ0", dut.occ_reg[0], 10'd5);
    ch_consumed = 6'b000001;
    @(negedge clk);
    ch_consumed = 6'd0;
    chk("consume_occ0", dut.occ_reg[0], 10'd4);
    chk("consume_no_error", error, 1'b0);
    ch_consumed = 6'b010000;
    @(negedge clk);
    ch_consumed = 6'd0;
    chk("underflow_error", error, 1'b1);
    chk("underflow_occ4", dut.occ_reg[4], 10'd0);
    $display("simultaneous write/consume and underflow sequence done");

    // QUEUE_RESET blocks an immediate commit for two cycles
    do_reset();
    commit_move(6'd0, 32'h10);
    commit_move(6'd1, 32'h20);
    load_words(4, 32'h30);
    issue(OP_QR, 6'b000011, 32'd0, s);
    chk("qr_ch_reset", ch_reset, 6'b000011);
    issue(OP_C, 6'd0, 32'd0, s);
    chk("qr_commit_stalls", 32'(s), 32'd2);
    chk("qr_commit_wr_en", wr_en, 6'b000001);
    chk("qr_ch_reset_dropped", ch_reset, 6'd0);
    chk("qr_wr_data", wr_data, 100'h0_00000031_00000032_00000033);
    @(negedge clk);
    chk("qr_occ0", dut.occ_reg[0], 10'd1);
    chk("qr_occ1", dut.occ_reg[1], 10'd0);
    $display("queue-reset blocking sequence done, stalls=%0d", s);

    // Reset mid-assembly discards the partial move
    do_reset();
    load_words(2, 32'h40);
    do_reset();
    load_words(2, 32'h50);
    issue(OP_C, 6'd3, 32'd0, s);
    chk("partial_discard_wr_en", wr_en, 6'd0);
    chk("partial_discard_error", error, 1'b1);
    $display("reset mid-assembly sequence done");

    // Out-of-range channel index
    do_reset();
    load_words(4, 32'h60);
    issue(OP_C, 6'd7, 32'd0, s);
    chk("bad_ch_wr_en", wr_en, 6'd0);
    chk("bad_ch_error", error, 1'b1);
    $display("out-of-range channel sequence done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stepdir_dispatch.md
# stepdir_dispatch

Command-side controller for a bank of `stepdir` channels. It accepts a 32-bit command word stream with valid/ready handshake and assembles move records from it. Each move record is written into the selected channel's move FIFO. The block also fans out per-channel clock-reset and queue-reset strobes. It sits between the host command decoder and the stepdir instances, and tracks per-channel FIFO occupancy so that no channel's FIFO is ever overrun.

## Interface
Parameters:
- `NUM_CHANNELS`, 6: number of stepdir channels driven.
- `DATA_WIDTH`, 100: move record width; must match the stepdir queue width.
- `MOVE_COUNT`, 512: per-channel FIFO depth.
- `WORDS`, derived as ceil(DATA_WIDTH/32): number of data words per move (4 at the default width).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `cmd_valid`, in, 1: command word valid.
- `cmd_ready`, out, 1: command accepted this cycle when high together with `cmd_valid`.
- `cmd_op`, in, 2: 0 = MOVE_WORD, 1 = MOVE_COMMIT, 2 = RESET_CLOCK, 3 = QUEUE_RESET.
- `cmd_arg`, in, NUM_CHANNELS: channel index in the low clog2 bits for COMMIT; channel mask for ops 2 and 3.
- `cmd_data`, in, 32: payload word; clock value for RESET_CLOCK.
- `ch_consumed`, in, NUM_CHANNELS: one-cycle pulse per channel each time its stepdir pops its FIFO.
- `wr_data`, out, DATA_WIDTH: shared queue write data.
- `wr_en`, out, NUM_CHANNELS: one-hot write strobe.
- `do_reset_clock`, out, NUM_CHANNELS: clock-reset strobes.
- `reset_clock`, out, 32: shared clock value.
- `ch_reset`, out, NUM_CHANNELS: queue-reset strobes.
- `error`, out, 1: sticky protocol error.

## Operation
- Assembly register `asm` is WORDS*32 bits wide.
- MOVE_WORD: `asm <= {asm, cmd_data}`, shifting the register left by 32 bits. `wcnt` increments and saturates at WORDS.
- MOVE_COMMIT:
  - Valid only when `wcnt == WORDS`. Otherwise `error` is set, nothing is written, and `wcnt` is cleared.
  - Channel index >= NUM_CHANNELS: `error` is set, nothing is written.
  - Target occupancy == MOVE_COUNT: the command is stalled. `cmd_ready` stays low until occupancy drops, and the command is then accepted.
  - On acceptance: `wr_data <= asm[DATA_WIDTH-1:0]`, `wr_en[ch]` pulses, `wcnt <= 0`.
- RESET_CLOCK: `reset_clock <= cmd_data`; `do_reset_clock <= mask` for one cycle.
- QUEUE_RESET:
  - `ch_reset <= mask` for one cycle.
  - Occupancy of every masked channel is forced to 0.
  - Masked channels are blocked for COMMIT for 2 cycles after the strobe, because the stepdir `queue_empty` is delayed. A COMMIT to a blocked channel stalls via `cmd_ready`.
- Occupancy counter per channel, width clog2(MOVE_COUNT)+1:
  - +1 on `wr_en[ch]` and −1 on `ch_consumed[ch]`; both in the same cycle leave it unchanged.
  - `ch_consumed` with occupancy 0 sets `error` and leaves the counter at 0.
  - QUEUE_RESET overrides both the increment and the decrement.
- `error` is cleared only by `reset`.
- `cmd_ready` is combinational: high except during a COMMIT stall or while `reset` is asserted.

## Timing
- All strobes (`wr_en`, `do_reset_clock`, `ch_reset`) are registered and assert exactly one cycle after the accepting handshake. They are never asserted for more than one cycle per command.
- `wr_data` and `reset_clock` are valid in the same cycle as their strobe and hold afterwards.
- Throughput: one command per cycle, so back-to-back COMMITs to different channels are permitted.
- The occupancy check uses the registered counter plus any pending `wr_en` bit. As a result, back-to-back COMMITs to the same channel can never exceed MOVE_COUNT.
- Reset values:
  - All outputs 0: `wr_data`, `wr_en`, `do_reset_clock`, `reset_clock`, `ch_reset`, `error`.
  - `asm` = 0, `wcnt` = 0, all occupancies 0, block timers 0.
  - `cmd_ready` = 0 while `reset` is high.
- `reset` asserted mid-assembly discards the partial move. Any strobe scheduled for the next cycle is suppressed.

## Test plan
- **Move write:** 4 MOVE_WORDs 0x0000000A, 0x11111111, 0x22222222, 0x33333333, then COMMIT ch2 -> one cycle later `wr_en` = 6'b000100 and `wr_data` = 100'hA_11111111_22222222_33333333; occupancy[2] = 1.
- **Short commit:** 3 MOVE_WORDs then COMMIT ch0 -> no `wr_en`, `error` = 1 and stays 1 until `reset`.
- **Full-FIFO stall:** 512 commits to ch1 with no `ch_consumed`, then a 513th commit -> `cmd_ready` low. A single `ch_consumed[1]` pulse -> the command is accepted and `wr_en[1]` pulses; occupancy stays 512.
- **Simultaneous write and consume:** commit to ch0 in the same cycle as `ch_consumed[0]` with occupancy 5 -> occupancy stays 5.
- **QUEUE_RESET blocking:** QUEUE_RESET mask 6'b000011 followed immediately by COMMIT ch0 -> `ch_reset` = 6'b000011 for one cycle, occupancy[0..1] = 0, and the commit is stalled 2 cycles before `wr_en[0]`.
- **RESET_CLOCK:** RESET_CLOCK mask 6'b101000 with data 0xDEADBEEF -> `do_reset_clock` = 6'b101000 for one cycle with `reset_clock` = 0xDEADBEEF.
